// File: rtl/cd_pkg.sv
// Shared definitions for the cd_pila core: instruction field layout,
// ALU operation codes and the instruction decode helper.
package cd_pkg;
  localparam int OPW    = 6;
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 10;
  localparam int RA1_HI = 11;
  localparam int RA1_LO = 8;
  localparam int RA2_HI = 7;
  localparam int RA2_LO = 4;
  localparam int WA3_HI = 3;
  localparam int WA3_LO = 0;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 4;
  localparam int TGT_HI = 9;
  localparam int TGT_LO = 0;

  typedef enum logic [2:0] {
    ALU_A    = 3'b000,
    ALU_NOTA = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_NEGA = 3'b110,
    ALU_NEGB = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [OPW-1:0] opcode;
    logic [3:0]     ra1;
    logic [3:0]     ra2;
    logic [3:0]     wa3;
    logic [7:0]     imm;
    logic [9:0]     tgt;
  } fields_t;

  // Fields overlap on purpose; each consumer picks the one it needs.
  function automatic fields_t decode(input logic [15:0] i);
    fields_t f;
    f.opcode = i[OP_HI:OP_LO];
    f.ra1    = i[RA1_HI:RA1_LO];
    f.ra2    = i[RA2_HI:RA2_LO];
    f.wa3    = i[WA3_HI:WA3_LO];
    f.imm    = i[IMM_HI:IMM_LO];
    f.tgt    = i[TGT_HI:TGT_LO];
    return f;
  endfunction
endpackage

// File: rtl/alu.sv
// Eight-function ALU; carry only meaningful for add and subtract.
module alu
  import cd_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] y,
  output logic          cout
);
  logic [DW:0] add_w, sub_w;

  assign add_w = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1 so carry-out reads 1 when there is no borrow.
  assign sub_w = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);

  // Result and carry selection.
  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (alu_op_e'(op))
      ALU_A:    y = a;
      ALU_NOTA: y = ~a;
      ALU_ADD:  {cout, y} = add_w;
      ALU_SUB:  {cout, y} = sub_w;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_NEGA: y = DW'(0) - a;
      ALU_NEGB: y = DW'(0) - b;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/ffd.sv
// Enabled D register with asynchronous active-low clear.
module ffd #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // Clear immediately on reset, otherwise load when enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/mux2.sv
// Two-input multiplexer.
module mux2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/regfile.sv
// Register file: two combinational read ports, one write port, r0 hardwired 0.
module regfile #(
  parameter int DW   = 8,
  parameter int NREG = 16
) (
  input  logic                    clk,
  input  logic                    we3,
  input  logic [$clog2(NREG)-1:0] ra1,
  input  logic [$clog2(NREG)-1:0] ra2,
  input  logic [$clog2(NREG)-1:0] wa3,
  input  logic [DW-1:0]           wd3,
  output logic [DW-1:0]           rd1,
  output logic [DW-1:0]           rd2
);
  logic [DW-1:0] rf [NREG];

  // Storage is deliberately not reset; r0 is never written.
  always_ff @(posedge clk) begin
    if (we3 && wa3 != '0) rf[wa3] <= wd3;
  end

  assign rd1 = (ra1 == '0) ? '0 : rf[ra1];
  assign rd2 = (ra2 == '0) ? '0 : rf[ra2];
endmodule

// File: rtl/rstack.sv
// Return-address stack with overflow/underflow protection and sticky error.
module rstack #(
  parameter int AW = 10,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic          err
);
  localparam int IW = $clog2(SD);

  // sp counts entries 0..SD, hence one bit wider than the index.
  logic [IW:0]   sp;
  logic [AW-1:0] mem [SD];
  logic [IW-1:0] wr_idx, rd_idx;

  assign wr_idx = sp[IW-1:0];
  assign rd_idx = sp[IW-1:0] - IW'(1);
  assign top    = mem[rd_idx];
  assign full   = (sp == (IW+1)'(SD));
  assign empty  = (sp == '0);

  // Pointer and error flag; simultaneous push+pop is a conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp  <= '0;
      err <= 1'b0;
    end else if (push && pop) begin
      err <= 1'b1;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else       sp  <= sp - (IW+1)'(1);
    end else if (push) begin
      if (full) err <= 1'b1;
      else      sp  <= sp + (IW+1)'(1);
    end
  end

  // Entry storage, not reset; a push into a full stack is dropped.
  always_ff @(posedge clk) begin
    if (push && !pop && !full) mem[wr_idx] <= din;
  end
endmodule

// File: rtl/sum.sv
// Modular adder (wraps at 2^W).
module sum #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/cd_pila.sv
// Single-cycle datapath: regfile + ALU + flags + pc with call/return stack.
module cd_pila
  import cd_pkg::*;
#(
  parameter int DW   = 8,
  parameter int AW   = 10,
  parameter int NREG = 16,
  parameter int SD   = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [15:0]    instr,
  output logic [AW-1:0]  pc,
  input  logic           s_inc,
  input  logic           s_inm,
  input  logic           we3,
  input  logic           wez,
  input  logic           wec,
  input  logic [2:0]     op_alu,
  input  logic           push,
  input  logic           pop,
  output logic           z,
  output logic           c,
  output logic [OPW-1:0] opcode,
  output logic           stk_full,
  output logic           stk_empty,
  output logic           stk_err
);
  localparam int RAW = $clog2(NREG);

  fields_t       f;
  logic [DW-1:0] rd1, rd2, alu_y, imm_x, wd3;
  logic          alu_c;
  logic [AW-1:0] pc_inc, tgt_x, seq_pc, pc_nxt, stk_top;

  assign f      = decode(instr);
  assign opcode = f.opcode;
  assign imm_x  = DW'(f.imm);
  assign tgt_x  = AW'(f.tgt);

  regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .clk(clk), .we3(we3),
    .ra1(f.ra1[RAW-1:0]), .ra2(f.ra2[RAW-1:0]), .wa3(f.wa3[RAW-1:0]),
    .wd3(wd3), .rd1(rd1), .rd2(rd2)
  );

  alu #(.DW(DW)) u_alu (.a(rd1), .b(rd2), .op(op_alu), .y(alu_y), .cout(alu_c));

  mux2 #(.W(DW)) u_wb_mux (.d0(alu_y), .d1(imm_x), .s(s_inm), .y(wd3));

  ffd #(.W(1)) u_zf (.clk(clk), .reset(reset), .en(wez), .d(alu_y == '0), .q(z));
  ffd #(.W(1)) u_cf (.clk(clk), .reset(reset), .en(wec), .d(alu_c),       .q(c));

  sum  #(.W(AW)) u_pc_inc  (.a(pc), .b(AW'(1)), .y(pc_inc));
  mux2 #(.W(AW)) u_seq_mux (.d0(tgt_x), .d1(pc_inc), .s(s_inc), .y(seq_pc));

  rstack #(.AW(AW), .SD(SD)) u_stk (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pc_inc),
    .top(stk_top), .full(stk_full), .empty(stk_empty), .err(stk_err)
  );

  // Next-pc priority: conflict, return, call, then sequential/jump.
  always_comb begin
    pc_nxt = seq_pc;
    if (push && pop) pc_nxt = seq_pc;
    else if (pop)    pc_nxt = stk_empty ? pc_inc : stk_top;
    else if (push)   pc_nxt = tgt_x;
  end

  ffd #(.W(AW)) u_pc (.clk(clk), .reset(reset), .en(1'b1), .d(pc_nxt), .q(pc));
endmodule

// File: doc/cd_pila.md
CD_PILA -- requirements
Module: cd_pila

Interface
REQ-001 Parameter DW, default 8: data/register width; SHALL be >= 8.
REQ-002 Parameter AW, default 10: PC width; SHALL be >= 10.
REQ-003 Parameter NREG, default 16: register count; SHALL be a power of two <= 16.
REQ-004 Parameter SD, default 4: return-stack depth; SHALL be a power of two >= 2.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-007 instr  in  16  instruction word from external program memory, combinational for the current pc.
REQ-008 pc  out  AW  current program counter.
REQ-009 s_inc  in  1  1 = sequential pc+1; 0 = jump to target.
REQ-010 s_inm  in  1  1 = write-back immediate; 0 = write-back ALU result.
REQ-011 we3  in  1  register-file write enable.
REQ-012 wez  in  1  zero-flag load enable.
REQ-013 wec  in  1  carry-flag load enable.
REQ-014 op_alu  in  3  ALU operation.
REQ-015 push  in  1  call: save pc+1 and jump to target.
REQ-016 pop  in  1  return: jump to the saved address.
REQ-017 z, c  out  1 each  registered zero and carry flags.
REQ-018 opcode  out  6  instr[15:10].
REQ-019 stk_full, stk_empty  out  1 each  return-stack status.
REQ-020 stk_err  out  1  sticky stack-error flag.

Function
REQ-021 Fields SHALL be: ra1=instr[11:8], ra2=instr[7:4], wa3=instr[3:0], imm=instr[11:4] zero-extended to DW, target=instr[9:0] zero-extended to AW; register addresses SHALL use their low log2(NREG) bits.
REQ-022 Reads SHALL be combinational; register 0 SHALL always read 0 and writes to it SHALL be ignored.
REQ-023 ALU ops SHALL be: 000 a, 001 ~a, 010 a+b, 011 a-b, 100 a&b, 101 a|b, 110 -a, 111 -b, all modulo 2^DW.
REQ-024 ALU carry SHALL be the carry-out of a+b (010) or of a+~b+1 (011, 1 = no borrow); for all other ops it SHALL be 0.
REQ-025 When wez=1, z SHALL load (ALU result == 0) at the clock edge; when wec=1, c SHALL load the ALU carry; otherwise both SHALL hold.
REQ-026 When we3=1, register wa3 SHALL be written at the clock edge with imm if s_inm=1, else with the ALU result.
REQ-027 Next pc, in priority order: push&pop -> per s_inc, no stack change, stk_err set; pop -> stack top, or pc+1 if empty; push -> target; s_inc=1 -> pc+1; else -> target. pc+1 SHALL wrap modulo 2^AW.
REQ-028 A push SHALL store pc+1 and increment the stack pointer; when full, the store SHALL be dropped, the jump SHALL still occur, and stk_err SHALL be set.
REQ-029 A pop SHALL decrement the stack pointer; when empty, the pointer SHALL stay at 0 and stk_err SHALL be set.
REQ-030 stk_full SHALL be 1 at SD entries and stk_empty at 0 entries, both combinational from the pointer.
REQ-031 Every instruction SHALL complete in one cycle; the effect of instruction N SHALL be visible to instruction N+1.

Reset
REQ-032 While reset=0: pc=0, z=0, c=0, stack pointer=0, stk_err=0, immediately and independently of clk.
REQ-033 Register-file and stack storage SHALL NOT be reset; stk_err SHALL clear only on reset.
REQ-034 A reset asserted mid-instruction SHALL cancel it; the first instruction after release SHALL be fetched at pc=0.

Structure
REQ-035 Shared package cd_pkg SHALL hold the ALU op constants, instruction field bit positions and opcode width.
REQ-036 The return stack SHALL be sub-module rstack (parameters AW, SD), exposing push, pop, din, top, full, empty and err.
REQ-037 The existing regfile, alu, mux2, sum and ffd blocks SHALL be reused, parametrised by DW/AW where needed.

Verification
REQ-038 Test 1: s_inm=1, we3=1, instr imm=0x5A, wa3=3; next cycle op_alu=000, ra1=3 -> ALU result 0x5A.
REQ-039 Test 2: r1=0xFF, r2=0x01, op 010, wez=wec=1 -> z=1, c=1; op 011 with r1=0x01, r2=0x02 -> c=0, result 0xFF.
REQ-040 Test 3: push at pc=5 with target 0x100 -> pc=0x100 and stack top=6; then pop -> pc=6 and stk_empty=1.
REQ-041 Test 4: five pushes with SD=4 -> stk_full after the 4th push, stk_err=1 after the 5th, and four pops return the first four saved addresses; a further pop -> pc+1 with stk_err still 1.
REQ-042 Test 5: with pc=0x3FF and s_inc=1 -> pc=0x000; reset pulsed low mid-cycle -> pc, z, c, stk_err all 0 before the next clk edge.
REQ-043 Test 6: push and pop asserted together with s_inc=1 -> pc+1, stack pointer unchanged, stk_err=1.
